// File: rtl/z80_wb_pkg.sv
// Shared definitions for the Z80 to Wishbone bridge: cycle tags and bus FSM states.
package z80_wb_pkg;

  localparam logic [1:0] TAG_MEM  = 2'b00;
  localparam logic [1:0] TAG_IO   = 2'b01;
  localparam logic [1:0] TAG_INTA = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bus_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Ack timeout counter: counts enabled clocks since the last clear and flags the
// clock on which the LIMIT-th enabled clock is reached. LIMIT=0 never expires.
module wb_timeout_cnt #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WIDTH-1:0] LAST = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) cnt <= '0;
    else if (en_i)      cnt <= cnt + WIDTH'(1);
  end

  // Fires during the LIMIT-th enabled clock so the owner ends the cycle on that edge.
  assign expired_o = (LIMIT > 0) && en_i && (cnt == LAST);

endmodule

// File: rtl/z80_wb_bridge.sv
// Z80 bus to Wishbone B4 classic master bridge: one Wishbone cycle per CPU
// memory, I/O or interrupt-acknowledge access, stalling the CPU via WAIT.
module z80_wb_bridge #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int IO_ADR_W  = 8,
  parameter int TIMEOUT   = 255,
  parameter int SKIP_RFSH = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_a_i,
  input  logic [DATA_W-1:0] cpu_d_i,
  output logic [DATA_W-1:0] cpu_d_o,
  input  logic              cpu_mreq_n_i,
  input  logic              cpu_iorq_n_i,
  input  logic              cpu_rd_n_i,
  input  logic              cpu_wr_n_i,
  input  logic              cpu_m1_n_i,
  input  logic              cpu_rfsh_n_i,
  output logic              cpu_wait_n_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [1:0]        wbm_tga_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic              bus_err_o,
  output logic              err_sticky_o,
  input  logic              err_clr_i
);
  import z80_wb_pkg::*;

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] IO_MASK = {ADDR_W{1'b1}} >> (ADDR_W - IO_ADR_W);

  bus_state_e state, state_d;
  logic       rw_req, rfsh_blk, mem_req, io_req, inta_req, req;
  logic       start, finish, fail, expired;
  logic [1:0] tag;

  // Access decode; interrupt acknowledge outranks plain I/O since both use IORQ.
  assign rw_req   = !cpu_rd_n_i || !cpu_wr_n_i;
  assign rfsh_blk = (SKIP_RFSH != 0) && !cpu_rfsh_n_i;
  assign mem_req  = !cpu_mreq_n_i && rw_req && !rfsh_blk;
  assign io_req   = !cpu_iorq_n_i && cpu_m1_n_i && rw_req;
  assign inta_req = !cpu_iorq_n_i && !cpu_m1_n_i;
  assign req      = mem_req || io_req || inta_req;
  assign tag      = inta_req ? TAG_INTA : (io_req ? TAG_IO : TAG_MEM);

  // Ending without ack means err or timeout; a coincident err still wins.
  assign fail     = wbm_err_i || !wbm_ack_i;

  wb_timeout_cnt #(.WIDTH(TO_W), .LIMIT(TIMEOUT)) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (start),
    .en_i      (state == REQ),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d      = state;
    start        = 1'b0;
    finish       = 1'b0;
    cpu_wait_n_o = 1'b1;
    unique case (state)
      IDLE: if (req) begin
        state_d      = REQ;
        start        = 1'b1;
        cpu_wait_n_o = 1'b0;
      end
      REQ: begin
        cpu_wait_n_o = 1'b0;
        if (wbm_ack_i || wbm_err_i || expired) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE: if (cpu_mreq_n_i && cpu_iorq_n_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wbm_adr_o    <= '0;
      wbm_tga_o    <= TAG_MEM;
      wbm_dat_o    <= '0;
      wbm_we_o     <= 1'b0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      cpu_d_o      <= '0;
      bus_err_o    <= 1'b0;
      err_sticky_o <= 1'b0;
    end else begin
      bus_err_o <= finish && fail;
      if (start) begin
        wbm_adr_o <= (tag == TAG_MEM) ? cpu_a_i : (cpu_a_i & IO_MASK);
        wbm_tga_o <= tag;
        wbm_dat_o <= cpu_d_i;
        wbm_we_o  <= !inta_req && !cpu_wr_n_i;
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
      end
      if (finish) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        if (!wbm_we_o) cpu_d_o <= fail ? '1 : wbm_dat_i;
      end
      // A fresh error pulse beats a simultaneous clear.
      if (bus_err_o)      err_sticky_o <= 1'b1;
      else if (err_clr_i) err_sticky_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z80_wb_bridge.sv
// Directed self-checking bench for z80_wb_bridge (TIMEOUT=4 instance).
module tb_z80_wb_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d, cpu_d_o, wbm_dat_i, wbm_dat_o;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, wait_n;
  logic [15:0] wbm_adr;
  logic [1:0]  wbm_tga;
  logic        cyc, stb, we, ack, err, bus_err, sticky, err_clr;
  int          total = 0;
  int          bad   = 0;

  z80_wb_bridge #(.ADDR_W(16), .DATA_W(8), .IO_ADR_W(8), .TIMEOUT(4), .SKIP_RFSH(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_a_i(cpu_a), .cpu_d_i(cpu_d), .cpu_d_o(cpu_d_o),
    .cpu_mreq_n_i(mreq_n), .cpu_iorq_n_i(iorq_n), .cpu_rd_n_i(rd_n),
    .cpu_wr_n_i(wr_n), .cpu_m1_n_i(m1_n), .cpu_rfsh_n_i(rfsh_n),
    .cpu_wait_n_o(wait_n),
    .wbm_adr_o(wbm_adr), .wbm_tga_o(wbm_tga), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_ack_i(ack), .wbm_err_i(err),
    .bus_err_o(bus_err), .err_sticky_o(sticky), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1; rfsh_n = 1;
  endtask

  initial begin
    rst = 1; cpu_a = '0; cpu_d = '0; wbm_dat_i = '0; ack = 0; err = 0; err_clr = 0;
    idle_bus();
    tick(); tick();
    rst = 0;
    chk("rst_cyc",    32'(cyc),       0);
    chk("rst_stb_we", 32'({stb, we}), 0);
    chk("rst_adr",    32'(wbm_adr),   0);
    chk("rst_tga",    32'(wbm_tga),   0);
    chk("rst_dato",   32'(wbm_dat_o), 0);
    chk("rst_cpud",   32'(cpu_d_o),   0);
    chk("rst_err",    32'({bus_err, sticky}), 0);
    chk("rst_wait",   32'(wait_n),    1);

    // Memory read 0x1234, ack in third REQ clock with 0xA5
    cpu_a = 16'h1234; mreq_n = 0; rd_n = 0;
    #1 chk("mr_wait0", 32'(wait_n), 0);
    tick();
    chk("mr_cyc_stb", 32'({cyc, stb}), 3);
    chk("mr_adr",     32'(wbm_adr),    32'h1234);
    chk("mr_tga",     32'(wbm_tga),    0);
    chk("mr_we",      32'(we),         0);
    chk("mr_wait1",   32'(wait_n),     0);
    tick();
    chk("mr_stb2",    32'(stb),    1);
    chk("mr_wait2",   32'(wait_n), 0);
    tick();
    chk("mr_stb3",    32'(stb),    1);
    chk("mr_wait3",   32'(wait_n), 0);
    ack = 1; wbm_dat_i = 8'hA5;
    tick();
    ack = 0; wbm_dat_i = 8'h00;
    chk("mr_done_stb", 32'({cyc, stb}), 0);
    chk("mr_cpud",     32'(cpu_d_o),    32'hA5);
    chk("mr_wait_hi",  32'(wait_n),     1);
    chk("mr_no_err",   32'(bus_err),    0);
    tick();
    chk("mr_hold_cyc", 32'(cyc),    0);
    chk("mr_hold_cpud", 32'(cpu_d_o), 32'hA5);
    idle_bus(); tick();

    // I/O write 0xBEEF <- 0x5C, zero-wait ack; strobes held 3 more clocks
    cpu_a = 16'hBEEF; cpu_d = 8'h5C; iorq_n = 0; wr_n = 0;
    tick();
    chk("io_cyc",  32'(cyc),       1);
    chk("io_adr",  32'(wbm_adr),   32'h00EF);
    chk("io_tga",  32'(wbm_tga),   1);
    chk("io_we",   32'(we),        1);
    chk("io_dato", 32'(wbm_dat_o), 32'h5C);
    ack = 1;
    tick();
    ack = 0;
    chk("io_done_cyc", 32'(cyc),    0);
    chk("io_wait_hi",  32'(wait_n), 1);
    chk("io_cpud_kept", 32'(cpu_d_o), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("io_single", 32'({cyc, stb, wait_n}), 1);
    end
    idle_bus(); tick();

    // Interrupt acknowledge, ack 0xFF
    cpu_a = 16'h0038; iorq_n = 0; m1_n = 0;
    tick();
    chk("inta_tga", 32'(wbm_tga), 2);
    chk("inta_we",  32'({cyc, we}), 2);
    ack = 1; wbm_dat_i = 8'hFF;
    tick();
    ack = 0; wbm_dat_i = 8'h00;
    chk("inta_cpud", 32'(cpu_d_o), 32'hFF);
    idle_bus(); tick();

    // Fast memory read 0x0100 -> 0x12
    cpu_a = 16'h0100; mreq_n = 0; rd_n = 0;
    tick();
    ack = 1; wbm_dat_i = 8'h12;
    tick();
    ack = 0; wbm_dat_i = 8'h00;
    chk("fr_cpud", 32'(cpu_d_o), 32'h12);
    chk("fr_err",  32'(bus_err), 0);
    idle_bus(); tick();

    // Timeout: no ack, stb for exactly 4 clocks
    cpu_a = 16'h4000; mreq_n = 0; rd_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_stb", 32'({stb, wait_n}), 2);
    end
    tick();
    chk("to_stb_end", 32'(stb),     0);
    chk("to_cpud",    32'(cpu_d_o), 32'hFF);
    chk("to_buserr",  32'(bus_err), 1);
    chk("to_sticky0", 32'(sticky),  0);
    tick();
    chk("to_pulse1",  32'(bus_err), 0);
    chk("to_sticky1", 32'(sticky),  1);
    idle_bus(); tick();
    chk("to_sticky_hold", 32'(sticky), 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("to_sticky_clr", 32'(sticky), 0);

    // ack+err together counts as error; clear coincident with pulse keeps sticky
    cpu_a = 16'h2222; mreq_n = 0; rd_n = 0;
    tick();
    ack = 1; err = 1; wbm_dat_i = 8'h77;
    tick();
    ack = 0; err = 0; wbm_dat_i = 8'h00;
    chk("ae_cpud",   32'(cpu_d_o), 32'hFF);
    chk("ae_buserr", 32'(bus_err), 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("ae_sticky", 32'(sticky), 1);
    idle_bus();
    err_clr = 1; tick(); err_clr = 0;
    chk("ae_clr", 32'(sticky), 0);

    // Refresh with MREQ low must not start a cycle
    cpu_a = 16'h0055; mreq_n = 0; rfsh_n = 0; rd_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rfsh_nocyc", 32'({cyc, wait_n}), 1);
    end
    idle_bus(); tick();

    // Reset during REQ, then request still held restarts a cycle
    cpu_a = 16'h8001; mreq_n = 0; rd_n = 0;
    tick();
    chk("rr_cyc", 32'(cyc), 1);
    rst = 1;
    tick();
    chk("rr_cyc0",  32'({cyc, stb, we}), 0);
    chk("rr_adr0",  32'(wbm_adr), 0);
    chk("rr_cpud0", 32'(cpu_d_o), 0);
    chk("rr_err0",  32'({bus_err, sticky}), 0);
    rst = 0;
    tick();
    chk("rr_restart", 32'({cyc, stb}), 3);
    chk("rr_adr",     32'(wbm_adr), 32'h8001);
    ack = 1; wbm_dat_i = 8'h3C;
    tick();
    ack = 0;
    chk("rr_cpud", 32'(cpu_d_o), 32'h3C);
    idle_bus(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/z80_wb_bridge.md
Z80_WB_BRIDGE -- requirements
Module: z80_wb_bridge

Interface
REQ-001 Parameters SHALL be: ADDR_W, 16, CPU/Wishbone address width; DATA_W, 8, data width; IO_ADR_W, 8, low address bits kept on I/O cycles (upper bits driven 0); TIMEOUT, 255, ack timeout in clocks (0 = disabled); SKIP_RFSH, 1, ignore refresh cycles.
REQ-002 clk_i  in  1  single clock; all logic on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 cpu_a_i  in  ADDR_W  CPU address; cpu_d_i  in  DATA_W  CPU write data; cpu_d_o  out  DATA_W  read data to CPU.
REQ-005 cpu_mreq_n_i, cpu_iorq_n_i, cpu_rd_n_i, cpu_wr_n_i, cpu_m1_n_i, cpu_rfsh_n_i  in  1 each  Z80 bus strobes, active-low.
REQ-006 cpu_wait_n_o  out  1  wait request to CPU, low = stall.
REQ-007 wbm_adr_o  out  ADDR_W; wbm_tga_o  out  2; wbm_dat_o  out  DATA_W; wbm_dat_i  in  DATA_W; wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1; wbm_ack_i, wbm_err_i  in  1: Wishbone B4 classic master.
REQ-008 bus_err_o  out  1  one-clock pulse on wbm_err_i or timeout; err_sticky_o  out  1  set by any error, cleared by err_clr_i  in  1.

Function
REQ-009 Access request SHALL be: (mreq low AND (rd OR wr low)), memory; (iorq low AND m1 high AND (rd OR wr low)), I/O; (iorq low AND m1 low), interrupt acknowledge; with SKIP_RFSH=1, mreq with rfsh low SHALL NOT start a cycle.
REQ-010 Tags SHALL be TAG_MEM=00, TAG_IO=01, TAG_INTA=10; interrupt acknowledge is a read.
REQ-011 States SHALL be IDLE, REQ, DONE.
REQ-012 IDLE + request: latch address (I/O masked to IO_ADR_W), cpu_d_i, we=~wr_n, tag; next clock cyc=stb=1, state REQ.
REQ-013 REQ: outputs stay stable; on wbm_ack_i or wbm_err_i or timeout, cyc=stb=0 next clock, state DONE.
REQ-014 Read ack SHALL latch wbm_dat_i into cpu_d_o; read err or timeout SHALL load all-ones; cpu_d_o holds until next read completes.
REQ-015 ack and err in the same clock SHALL be treated as err.
REQ-016 cpu_wait_n_o SHALL be combinational: 0 when (IDLE and request) or REQ; 1 otherwise, including the DONE clock the data is valid.
REQ-017 DONE SHALL persist until mreq_n and iorq_n both high, then IDLE; no second cycle per CPU access, however long the CPU holds strobes.
REQ-018 Timeout counter SHALL clear on REQ entry, increment each REQ clock; reaching TIMEOUT ends the cycle (REQ-013); TIMEOUT=0 waits indefinitely.
REQ-019 Error clock: bus_err_o=1 for exactly one clock; err_sticky_o set next clock; err_clr_i coincident with new error SHALL leave sticky set.
REQ-020 Minimum latency: request seen clock N, stb at N+1, ack at N+1 -> data at N+2, wait_n high at N+2.

Reset
REQ-021 rst_i SHALL force IDLE, cyc=stb=we=0, adr=0, tga=00, wbm_dat_o=0, cpu_d_o=0, bus_err_o=0, err_sticky_o=0, timeout count 0, effective the clock rst_i sampled high.
REQ-022 Reset mid-REQ SHALL drop cyc/stb immediately; a request still present after reset release SHALL start a new cycle.

Structure
REQ-023 Package z80_wb_pkg SHALL hold tag constants TAG_MEM/TAG_IO/TAG_INTA and the state enum.
REQ-024 Timeout counter SHALL be sub-module wb_timeout_cnt (params WIDTH, LIMIT; ports clk_i, rst_i, clr_i, en_i, expired_o).

Verification
REQ-025 Memory read A=0x1234, ack after 3 clocks, dat=0xA5 -> stb 3 clocks, tga=00, we=0, cpu_d_o=0xA5, wait_n low 4 clocks.
REQ-026 I/O write A=0xBEEF, D=0x5C, ack same clock as stb -> adr=0x00EF, tga=01, we=1, dat_o=0x5C, one cycle only.
REQ-027 INTA (m1, iorq low), ack dat=0xFF -> tga=10, we=0, cpu_d_o=0xFF.
REQ-028 TIMEOUT=4, no ack -> stb exactly 4 clocks, cpu_d_o=all-ones, bus_err_o pulse, err_sticky_o=1 until err_clr_i.
REQ-029 Refresh mreq with rfsh low -> no cyc; rst_i during REQ -> cyc=0 next clock, all outputs at reset values.
